// File: rtl/offset_restore.sv
// rtl/offset_restore.sv - byte FIFO that adds OFFSET back to each offset-encoded byte on push.
// Optional pop counter port xfer_count when OFFSET_RESTORE_STATS_EN is defined.
module offset_restore #(
  parameter int         DEPTH  = 4,
  parameter logic [7:0] OFFSET = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [4:0]  level
`ifdef OFFSET_RESTORE_STATS_EN
  ,
  output logic [15:0] xfer_count
`endif
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [7:0]    wr_data_d;
  logic          push, pop;

  // Handshake flags come only from registered occupancy, so in_ready never
  // depends on out_ready within a cycle.
  always_comb begin
    in_ready  = (level_q < DEPTH_L);
    out_valid = (level_q != 5'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_data_d = in_data + OFFSET;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  assign out_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 5'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; a write coincident with reset is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_data_d;
  end

`ifdef OFFSET_RESTORE_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (pop) xfer_count_d = xfer_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) xfer_count_q <= 16'd0;
    else     xfer_count_q <= xfer_count_d;
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_offset_restore.sv
// tb/tb_offset_restore.sv - scoreboard bench for offset_restore; stats checks when OFFSET_RESTORE_STATS_EN is defined.
module tb_offset_restore;
  localparam int         DEPTH  = 4;
  localparam logic [7:0] OFFSET = 8'h10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [4:0] level;
`ifdef OFFSET_RESTORE_STATS_EN
  logic [15:0] xfer_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  offset_restore #(.DEPTH(DEPTH), .OFFSET(OFFSET)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level)
`ifdef OFFSET_RESTORE_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  // One cycle from the falling edge: drive inputs, decide handshakes from
  // settled outputs, update the scoreboard, return what was popped.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy,
                     output logic pushed, output logic popped,
                     output logic [7:0] got, output logic [7:0] exp);
    logic [7:0] enc;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    pushed = iv && in_ready && !rst;
    popped = out_valid && ordy && !rst;
    got    = out_data;
    exp    = 8'hxx;
    enc    = id + OFFSET;
    if (pushed) sb.push_back(enc);
    if (popped && sb.size() > 0) exp = sb.pop_front();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic p, q;
    logic [7:0] g, e;
    rst = 1'b1;
    cyc(1'b1, 8'h11, 1'b1, p, q, g, e);
    rst = 1'b0;
    sb.delete();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
  endtask

  task automatic test_single();
    logic p, q;
    logic [7:0] g, e;
    cyc(1'b1, 8'h30, 1'b1, p, q, g, e);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'h40) begin failures++; $display("FAIL single_data got=%h exp=40", out_data); end
    cyc(1'b0, 8'h00, 1'b1, p, q, g, e);
    checks++; if (q !== 1'b1 || g !== 8'h40 || e !== 8'h40) begin failures++; $display("FAIL single_pop popped=%b got=%h exp=%h req=40", q, g, e); end
    checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_level got=%0d/%b exp=0/0", level, out_valid); end
  endtask

  task automatic test_wrap();
    logic p, q;
    logic [7:0] g, e;
    logic [7:0] vin [3];
    logic [7:0] vout [3];
    int n;
    vin[0] = 8'hF0; vin[1] = 8'hF5; vin[2] = 8'h00;
    vout[0] = 8'h00; vout[1] = 8'h05; vout[2] = 8'h10;
    for (int i = 0; i < 3; i++) cyc(1'b1, vin[i], 1'b0, p, q, g, e);
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      cyc(1'b0, 8'h00, 1'b1, p, q, g, e);
      if (q) begin
        checks++; if (g !== e || g !== vout[n]) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", n, g, vout[n]); end
        n++;
      end
    end
    checks++; if (n != 3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", n); end
  endtask

  task automatic test_fill();
    logic p, q;
    logic [7:0] g, e;
    int acc;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, 8'hA0 + 8'(acc), 1'b0, p, q, g, e);
      if (p) acc++;
      if (c > 0) begin
        checks++; if (g !== 8'hB0) begin failures++; $display("FAIL fill_hold got=%h exp=b0", g); end
      end
    end
    checks++; if (acc != 4) begin failures++; $display("FAIL fill_accepted got=%0d exp=4", acc); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    checks++; if (level !== 5'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", level); end
  endtask

  task automatic test_full_simul();
    logic p, q;
    logic [7:0] g, e;
    int n;
    cyc(1'b1, 8'hA4, 1'b1, p, q, g, e);
    checks++; if (p !== 1'b0 || q !== 1'b1) begin failures++; $display("FAIL full_handshake push=%b pop=%b exp=0/1", p, q); end
    checks++; if (g !== e) begin failures++; $display("FAIL full_pop_data got=%h exp=%h", g, e); end
    checks++; if (in_ready !== 1'b1 || level !== 5'd3) begin failures++; $display("FAIL full_after ready=%b level=%0d exp=1/3", in_ready, level); end
    cyc(1'b1, 8'hA4, 1'b0, p, q, g, e);
    checks++; if (p !== 1'b1) begin failures++; $display("FAIL full_fifth_push got=%b exp=1", p); end
    n = 0;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      cyc(1'b0, 8'h00, 1'b1, p, q, g, e);
      if (q) begin
        checks++; if (g !== e) begin failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", n, g, e); end
        n++;
      end
    end
    checks++; if (n != 4 || level !== 5'd0) begin failures++; $display("FAIL full_drain_count got=%0d level=%0d exp=4/0", n, level); end
  endtask

  task automatic test_reset_mid();
    logic p, q;
    logic [7:0] g, e;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, p, q, g, e);
    checks++; if (level !== 5'd3) begin failures++; $display("FAIL rmid_level_pre got=%0d exp=3", level); end
    rst = 1'b1;
    cyc(1'b1, 8'h77, 1'b1, p, q, g, e);
    rst = 1'b0;
    sb.delete();
    checks++; if (out_valid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_after valid=%b level=%0d ready=%b exp=0/0/1", out_valid, level, in_ready); end
    cyc(1'b1, 8'h55, 1'b0, p, q, g, e);
    cyc(1'b0, 8'h00, 1'b1, p, q, g, e);
    checks++; if (q !== 1'b1 || g !== 8'h65 || g !== e) begin failures++; $display("FAIL rmid_next popped=%b got=%h exp=65", q, g); end
  endtask

  task automatic test_back_to_back();
    logic p, q;
    logic [7:0] g, e;
    int sent, cyc_n;
    sent = 0;
    cyc_n = 0;
    while ((sent < 1000 || sb.size() > 0) && cyc_n < 6000) begin
      cyc((sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom),
          ($urandom_range(0, 3) != 0), p, q, g, e);
      cyc_n++;
      if (p) sent++;
      if (q) begin
        checks++; if (g !== e) begin failures++; $display("FAIL rand_data cycle=%0d got=%h exp=%h", cyc_n, g, e); end
      end
      checks++; if (level !== 5'(sb.size())) begin failures++; $display("FAIL rand_level cycle=%0d got=%0d exp=%0d", cyc_n, level, sb.size()); end
    end
    checks++; if (sent != 1000 || sb.size() != 0) begin failures++; $display("FAIL rand_timeout sent=%0d left=%0d exp=1000/0", sent, sb.size()); end
  endtask

`ifdef OFFSET_RESTORE_STATS_EN
  task automatic test_stats();
    logic p, q;
    logic [7:0] g, e;
    int pops, cyc_n;
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, p, q, g, e);
    rst = 1'b0;
    sb.delete();
    checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL stats_reset got=%0d exp=0", xfer_count); end
    pops = 0;
    cyc_n = 0;
    while (pops < 65537 && cyc_n < 66000) begin
      cyc(1'b1, 8'(cyc_n), 1'b1, p, q, g, e);
      cyc_n++;
      if (q) pops++;
    end
    checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL stats_wrap got=%0d exp=1 pops=%0d", xfer_count, pops); end
    for (int c = 0; c < 10 && sb.size() > 0; c++) cyc(1'b0, 8'h00, 1'b1, p, q, g, e);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_wrap();
    test_fill();
    test_full_simul();
    test_reset_mid();
    test_back_to_back();
`ifdef OFFSET_RESTORE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
